operand_fetch: RTL and testbench
================================

Name: operand_fetch

Overview:
- Register-read stage and ID/EX pipeline register that sits directly downstream of the 32x64 register file in the pipelined 64-bit core.
- Takes the regfile's two read ports and resolves data hazards by bypassing results from the EX, MEM and WB stages. The regfile has no internal write-to-read bypass, so WB forwarding happens here.
- Detects load-use hazards, inserts bubbles, honours flushes, and latches operands and control into EX.

Parameters:
- XLEN, 64, datapath width.
- CTRL_W, 16, width of the opaque control bundle passed through to EX.
- CNT_W, 32, width of the stall-cycle performance counter.

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- id_valid  in  1  decode slot holds a real instruction.
- id_rn, id_rm, id_rd  in  5 each  source and destination register numbers (id_rn/id_rm also drive regfile ReadRegister1/2).
- id_use_rn, id_use_rm  in  1 each  the instruction actually reads that source.
- id_imm  in  XLEN  decoded immediate.
- id_ctrl  in  CTRL_W  control bundle.
- rf_rd1, rf_rd2  in  XLEN  regfile ReadData1/ReadData2.
- flush  in  1  squash the decode slot (branch redirect).
- ex_valid, ex_regwrite, ex_is_load  in  1 each  state of the instruction currently in EX.
- ex_rd  in  5,  ex_result  in  XLEN  EX-stage destination register and combinational ALU result.
- mem_regwrite  in  1,  mem_rd  in  5,  mem_result  in  XLEN  MEM-stage writeback candidate.
- wb_regwrite  in  1,  wb_rd  in  5,  wb_data  in  XLEN  the same values driven into the regfile write port.
- id_stall  out  1  combinational; upstream holds PC and the IF/ID register.
- q_valid  out  1  registered; EX slot valid.
- q_op_a, q_op_b  out  XLEN  registered resolved operands.
- q_imm  out  XLEN,  q_rd  out  5,  q_ctrl  out  CTRL_W  registered pass-through fields.
- stall_count  out  CNT_W  saturating count of load-use stall cycles.

Behaviour:
- Reset (async): q_valid=0, q_op_a=q_op_b=q_imm=0, q_rd=31, q_ctrl=0, stall_count=0. The id_stall value is combinational and is 0 whenever id_valid=0.
- Operand resolution is combinational, applied per operand (src = rn or rm, with its own regfile data):
  - src==31 (XZR): value is 0; never forwarded, even if a stage claims to write X31.
  - else if ex_valid & ex_regwrite & ex_rd==src & !ex_is_load: use ex_result.
  - else if mem_regwrite & mem_rd==src: use mem_result.
  - else if wb_regwrite & wb_rd==src: use wb_data.
  - else: use the regfile data.
  - Priority is strictly EX > MEM > WB (youngest producer wins).
- Load-use hazard:
  - hazard = id_valid & ex_valid & ex_is_load & ex_regwrite & ex_rd!=31 & ((id_use_rn & ex_rd==id_rn) | (id_use_rm & ex_rd==id_rm)).
  - An unused source never triggers a hazard.
- id_stall = hazard & !flush.
- Per posedge, in priority order:
  - flush: bubble (q_valid=0, q_ctrl=0, q_rd=31; operand registers may hold any value); id_stall=0.
  - hazard: bubble as above; stall_count increments, saturating at all-ones. The decode slot is held upstream and is re-evaluated next cycle, when the load is in MEM and its data arrives via mem_result.
  - id_valid=0: bubble.
  - otherwise: q_valid=1; q_op_a/q_op_b take the resolved values; q_imm, q_rd and q_ctrl take the id_* fields.
- Latency: one cycle from decode to EX. A load-use hazard costs exactly one bubble.
- Reset asserted mid-stall: all state clears; the stall count is lost; id_stall drops with id_valid.
- Forwarding and hazard logic ignore id_valid except as stated, so a bubble never causes a stall.

Decomposition:
- cpu_pkg holds:
  - REG_ZERO = 5'd31
  - XLEN, CTRL_W
  - fwd_sel_e enum {FWD_RF, FWD_EX, FWD_MEM, FWD_WB, FWD_ZERO}
  - the bubble ctrl constant CTRL_NOP = '0
- One sub-module, fwd_mux: src, regfile data and the three producer tuples in; resolved value and fwd_sel_e out. It is instantiated twice.
- Hazard detection, the pipeline register and the counter live in operand_fetch.

Test Plan:
- Plain read, no producers active: X3=0x11, X4=0x22 in the regfile; decode ADD rn=3, rm=4 -> next cycle q_valid=1, q_op_a=0x11, q_op_b=0x22.
- WB bypass: wb_regwrite=1, wb_rd=5, wb_data=0xABC; regfile still returns the stale 0x0 for rn=5 -> q_op_a=0xABC.
- Priority: ex_rd=mem_rd=wb_rd=7 with ex_result=1, mem_result=2, wb_data=3, rm=7 -> q_op_b=1. Then drop ex_regwrite -> 2. Then drop mem_regwrite -> 3.
- XZR: rn=31 with ex_regwrite=1, ex_rd=31, ex_result=0xFF -> q_op_a=0, no stall.
- Load-use: EX holds a load to X9; decode rm=9, id_use_rm=1 -> id_stall=1 for one cycle, bubble latched, stall_count=1. Next cycle load in MEM with mem_result=0x55 -> q_op_b=0x55, q_valid=1. Repeat with id_use_rm=0 -> no stall.
- Flush during hazard: same load-use case plus flush=1 -> id_stall=0, q_valid=0, stall_count unchanged. Then assert reset mid-stall -> all outputs at reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared types and constants for the core's register-read stage.
package cpu_pkg;

  localparam int XLEN   = 64;
  localparam int CTRL_W = 16;

  // X31 reads as zero and is never a forwarding target.
  localparam logic [4:0] REG_ZERO = 5'd31;

  // Bubble control bundle: an all-zero bundle is a no-op in EX.
  localparam logic [CTRL_W-1:0] CTRL_NOP = '0;

  // Which source supplied a resolved operand.
  typedef enum logic [2:0] {
    FWD_RF   = 3'd0,
    FWD_EX   = 3'd1,
    FWD_MEM  = 3'd2,
    FWD_WB   = 3'd3,
    FWD_ZERO = 3'd4
  } fwd_sel_e;

endpackage

// File: rtl/operand_fetch_fwd_mux.sv
// Per-operand bypass mux: picks the youngest in-flight producer of a source
// register, falling back to regfile data; X31 always resolves to zero.
module fwd_mux
  import cpu_pkg::*;
#(
  parameter int XLEN = cpu_pkg::XLEN
) (
  input  logic [4:0]      src,
  input  logic [XLEN-1:0] rf_data,
  input  logic            ex_valid,
  input  logic            ex_regwrite,
  input  logic            ex_is_load,
  input  logic [4:0]      ex_rd,
  input  logic [XLEN-1:0] ex_result,
  input  logic            mem_regwrite,
  input  logic [4:0]      mem_rd,
  input  logic [XLEN-1:0] mem_result,
  input  logic            wb_regwrite,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  output logic [XLEN-1:0] value,
  output fwd_sel_e        sel
);

  // A load in EX has no data yet, so it is never a bypass source here;
  // the hazard logic upstream stalls for that case instead.
  logic ex_hit;
  logic mem_hit;
  logic wb_hit;

  assign ex_hit  = ex_valid && ex_regwrite && !ex_is_load && (ex_rd == src);
  assign mem_hit = mem_regwrite && (mem_rd == src);
  assign wb_hit  = wb_regwrite && (wb_rd == src);

  // Select the source, youngest producer first (EX > MEM > WB > regfile).
  always_comb begin
    sel = FWD_RF;
    if (src == REG_ZERO) begin
      sel = FWD_ZERO;
    end else if (ex_hit) begin
      sel = FWD_EX;
    end else if (mem_hit) begin
      sel = FWD_MEM;
    end else if (wb_hit) begin
      sel = FWD_WB;
    end
  end

  // Steer the chosen source onto the output.
  always_comb begin
    value = rf_data;
    case (sel)
      FWD_ZERO: value = '0;
      FWD_EX:   value = ex_result;
      FWD_MEM:  value = mem_result;
      FWD_WB:   value = wb_data;
      default:  value = rf_data;
    endcase
  end

endmodule

// File: rtl/operand_fetch.sv
// Register-read stage and ID/EX pipeline register: bypasses EX/MEM/WB results
// onto the regfile read data, stalls on load-use, and latches into EX.
module operand_fetch
  import cpu_pkg::*;
#(
  parameter int XLEN   = cpu_pkg::XLEN,
  parameter int CTRL_W = cpu_pkg::CTRL_W,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [4:0]        id_rn,
  input  logic [4:0]        id_rm,
  input  logic [4:0]        id_rd,
  input  logic              id_use_rn,
  input  logic              id_use_rm,
  input  logic [XLEN-1:0]   id_imm,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic [XLEN-1:0]   rf_rd1,
  input  logic [XLEN-1:0]   rf_rd2,
  input  logic              flush,
  input  logic              ex_valid,
  input  logic              ex_regwrite,
  input  logic              ex_is_load,
  input  logic [4:0]        ex_rd,
  input  logic [XLEN-1:0]   ex_result,
  input  logic              mem_regwrite,
  input  logic [4:0]        mem_rd,
  input  logic [XLEN-1:0]   mem_result,
  input  logic              wb_regwrite,
  input  logic [4:0]        wb_rd,
  input  logic [XLEN-1:0]   wb_data,
  output logic              id_stall,
  output logic              q_valid,
  output logic [XLEN-1:0]   q_op_a,
  output logic [XLEN-1:0]   q_op_b,
  output logic [XLEN-1:0]   q_imm,
  output logic [4:0]        q_rd,
  output logic [CTRL_W-1:0] q_ctrl,
  output logic [CNT_W-1:0]  stall_count
);

  // Saturating increment: the counter parks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  logic [XLEN-1:0] val_a;
  logic [XLEN-1:0] val_b;
  fwd_sel_e        sel_a;
  fwd_sel_e        sel_b;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic            hazard;
  logic            bubble;

  fwd_mux #(.XLEN(XLEN)) u_fwd_a (
    .src          (id_rn),
    .rf_data      (rf_rd1),
    .ex_valid     (ex_valid),
    .ex_regwrite  (ex_regwrite),
    .ex_is_load   (ex_is_load),
    .ex_rd        (ex_rd),
    .ex_result    (ex_result),
    .mem_regwrite (mem_regwrite),
    .mem_rd       (mem_rd),
    .mem_result   (mem_result),
    .wb_regwrite  (wb_regwrite),
    .wb_rd        (wb_rd),
    .wb_data      (wb_data),
    .value        (val_a),
    .sel          (sel_a)
  );

  fwd_mux #(.XLEN(XLEN)) u_fwd_b (
    .src          (id_rm),
    .rf_data      (rf_rd2),
    .ex_valid     (ex_valid),
    .ex_regwrite  (ex_regwrite),
    .ex_is_load   (ex_is_load),
    .ex_rd        (ex_rd),
    .ex_result    (ex_result),
    .mem_regwrite (mem_regwrite),
    .mem_rd       (mem_rd),
    .mem_result   (mem_result),
    .wb_regwrite  (wb_regwrite),
    .wb_rd        (wb_rd),
    .wb_data      (wb_data),
    .value        (val_b),
    .sel          (sel_b)
  );

  // XZR reads are pinned to zero at the register input as well, so a zero
  // operand never depends on what the regfile drives for X31.
  assign op_a = (sel_a == FWD_ZERO) ? '0 : val_a;
  assign op_b = (sel_b == FWD_ZERO) ? '0 : val_b;

  // A load in EX feeding a source that decode actually reads must wait one
  // cycle; the load data then arrives through the MEM bypass.
  assign hazard = id_valid && ex_valid && ex_is_load && ex_regwrite &&
                  (ex_rd != REG_ZERO) &&
                  ((id_use_rn && (ex_rd == id_rn)) ||
                   (id_use_rm && (ex_rd == id_rm)));

  // A flush squashes the decode slot, so holding it upstream is pointless.
  assign id_stall = hazard && !flush;
  assign bubble   = flush || hazard || !id_valid;

  // ID/EX control: bubble on flush, hazard or empty decode slot.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q_valid <= 1'b0;
      q_rd    <= REG_ZERO;
      q_ctrl  <= CTRL_NOP;
    end else if (bubble) begin
      q_valid <= 1'b0;
      q_rd    <= REG_ZERO;
      q_ctrl  <= CTRL_NOP;
    end else begin
      q_valid <= 1'b1;
      q_rd    <= id_rd;
      q_ctrl  <= id_ctrl;
    end
  end

  // ID/EX data: operands and immediate load only for issued instructions.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q_op_a <= '0;
      q_op_b <= '0;
      q_imm  <= '0;
    end else if (!bubble) begin
      q_op_a <= op_a;
      q_op_b <= op_b;
      q_imm  <= id_imm;
    end
  end

  // Count load-use stall cycles; a flush in the same cycle is not a stall.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_count <= '0;
    end else if (hazard && !flush) begin
      stall_count <= sat_inc(stall_count);
    end
  end

endmodule

// File: tb/tb_operand_fetch.sv
// Directed bench for operand_fetch with a behavioural model checked each cycle.
module tb_operand_fetch;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        id_valid, id_use_rn, id_use_rm, flush;
  logic [4:0]  id_rn, id_rm, id_rd;
  logic [63:0] id_imm;
  logic [15:0] id_ctrl;
  logic [63:0] rf_rd1, rf_rd2;
  logic        ex_valid, ex_regwrite, ex_is_load;
  logic [4:0]  ex_rd;
  logic [63:0] ex_result;
  logic        mem_regwrite;
  logic [4:0]  mem_rd;
  logic [63:0] mem_result;
  logic        wb_regwrite;
  logic [4:0]  wb_rd;
  logic [63:0] wb_data;
  logic        id_stall, q_valid;
  logic [63:0] q_op_a, q_op_b, q_imm;
  logic [4:0]  q_rd;
  logic [15:0] q_ctrl;
  logic [31:0] stall_count;

  logic [63:0] rf [32];
  assign rf_rd1 = rf[id_rn];
  assign rf_rd2 = rf[id_rm];

  int checks = 0;
  int failures = 0;

  operand_fetch dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rn(id_rn), .id_rm(id_rm),
    .id_rd(id_rd), .id_use_rn(id_use_rn), .id_use_rm(id_use_rm), .id_imm(id_imm),
    .id_ctrl(id_ctrl), .rf_rd1(rf_rd1), .rf_rd2(rf_rd2), .flush(flush),
    .ex_valid(ex_valid), .ex_regwrite(ex_regwrite), .ex_is_load(ex_is_load),
    .ex_rd(ex_rd), .ex_result(ex_result), .mem_regwrite(mem_regwrite),
    .mem_rd(mem_rd), .mem_result(mem_result), .wb_regwrite(wb_regwrite),
    .wb_rd(wb_rd), .wb_data(wb_data), .id_stall(id_stall), .q_valid(q_valid),
    .q_op_a(q_op_a), .q_op_b(q_op_b), .q_imm(q_imm), .q_rd(q_rd),
    .q_ctrl(q_ctrl), .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Producers listed youngest first; the first matching one supplies the value.
  function automatic logic [63:0] model_read(input logic [4:0] src, input logic [63:0] rfv);
    logic        en [3];
    logic [4:0]  rd [3];
    logic [63:0] v  [3];
    en[0] = ex_valid && ex_regwrite && !ex_is_load; rd[0] = ex_rd;  v[0] = ex_result;
    en[1] = mem_regwrite;                           rd[1] = mem_rd; v[1] = mem_result;
    en[2] = wb_regwrite;                            rd[2] = wb_rd;  v[2] = wb_data;
    if (src == 5'd31) return 64'd0;
    for (int i = 0; i < 3; i++)
      if (en[i] && rd[i] == src) return v[i];
    return rfv;
  endfunction

  function automatic logic model_hazard();
    logic reads_load_dst;
    reads_load_dst = (id_use_rn && ex_rd == id_rn) || (id_use_rm && ex_rd == id_rm);
    return id_valid && ex_valid && ex_is_load && ex_regwrite && ex_rd != 5'd31 && reads_load_dst;
  endfunction

  logic        m_valid;
  logic [63:0] m_a, m_b, m_imm;
  logic [4:0]  m_rd;
  logic [15:0] m_ctrl;
  logic [31:0] m_cnt;
  logic        chk_en = 1'b0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_valid = 1'b0; m_a = '0; m_b = '0; m_imm = '0;
      m_rd = 5'd31; m_ctrl = '0; m_cnt = '0;
    end else if (flush || !id_valid) begin
      m_valid = 1'b0; m_rd = 5'd31; m_ctrl = '0;
    end else if (model_hazard()) begin
      m_valid = 1'b0; m_rd = 5'd31; m_ctrl = '0;
      if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
    end else begin
      m_valid = 1'b1;
      m_a = model_read(id_rn, rf_rd1);
      m_b = model_read(id_rm, rf_rd2);
      m_imm = id_imm; m_rd = id_rd; m_ctrl = id_ctrl;
    end
  end

  // Compare the DUT against the model away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_id_stall", id_stall, model_hazard() && !flush);
      chk("m_q_valid", q_valid, m_valid);
      chk("m_q_rd", q_rd, m_rd);
      chk("m_q_ctrl", q_ctrl, m_ctrl);
      chk("m_stall_count", stall_count, m_cnt);
      if (m_valid) begin
        chk("m_q_op_a", q_op_a, m_a);
        chk("m_q_op_b", q_op_b, m_b);
        chk("m_q_imm", q_imm, m_imm);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_producers();
    ex_valid = 0; ex_regwrite = 0; ex_is_load = 0; ex_rd = 0; ex_result = 0;
    mem_regwrite = 0; mem_rd = 0; mem_result = 0;
    wb_regwrite = 0; wb_rd = 0; wb_data = 0;
  endtask

  task automatic decode(input logic [4:0] rn, input logic [4:0] rm, input logic [4:0] rd,
                        input logic urn, input logic urm);
    id_valid = 1; id_rn = rn; id_rm = rm; id_rd = rd; id_use_rn = urn; id_use_rm = urm;
    id_imm = 64'h1000 + rd; id_ctrl = 16'hA500 | rd;
  endtask

  task automatic load_in_ex(input logic [4:0] rd);
    ex_valid = 1; ex_regwrite = 1; ex_is_load = 1; ex_rd = rd; ex_result = 64'hDEAD;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = 64'h0;
    rf[3] = 64'h11; rf[4] = 64'h22; rf[7] = 64'h77; rf[9] = 64'h99;
    id_valid = 0; id_rn = 0; id_rm = 0; id_rd = 0; id_use_rn = 0; id_use_rm = 0;
    id_imm = 0; id_ctrl = 0; flush = 0;
    clr_producers();
    #1 reset = 1;
    #1;
    chk("rst_q_valid", q_valid, 0);
    chk("rst_q_rd", q_rd, 31);
    chk("rst_q_op_a", q_op_a, 0);
    chk("rst_stall_count", stall_count, 0);
    chk("rst_id_stall", id_stall, 0);
    #10 reset = 0;
    chk_en = 1;

    // Plain read
    cyc();
    decode(3, 4, 2, 1, 1);
    cyc();
    chk("plain_valid", q_valid, 1);
    chk("plain_op_a", q_op_a, 64'h11);
    chk("plain_op_b", q_op_b, 64'h22);
    chk("plain_rd", q_rd, 2);

    // WB bypass over stale regfile
    decode(5, 4, 6, 1, 1);
    wb_regwrite = 1; wb_rd = 5; wb_data = 64'hABC;
    cyc();
    chk("wb_op_a", q_op_a, 64'hABC);

    // Priority EX > MEM > WB
    clr_producers();
    decode(3, 7, 8, 1, 1);
    ex_valid = 1; ex_regwrite = 1; ex_rd = 7; ex_result = 1;
    mem_regwrite = 1; mem_rd = 7; mem_result = 2;
    wb_regwrite = 1; wb_rd = 7; wb_data = 3;
    cyc();
    chk("prio_ex", q_op_b, 1);
    ex_regwrite = 0;
    cyc();
    chk("prio_mem", q_op_b, 2);
    mem_regwrite = 0;
    cyc();
    chk("prio_wb", q_op_b, 3);

    // XZR never forwarded
    clr_producers();
    decode(31, 4, 10, 1, 1);
    ex_valid = 1; ex_regwrite = 1; ex_rd = 31; ex_result = 64'hFF; ex_is_load = 1;
    #1 chk("xzr_no_stall", id_stall, 0);
    cyc();
    chk("xzr_op_a", q_op_a, 0);
    chk("xzr_valid", q_valid, 1);

    // Load-use: one bubble, then MEM bypass
    clr_producers();
    decode(3, 9, 11, 1, 1);
    load_in_ex(9);
    #1 chk("lu_stall", id_stall, 1);
    cyc();
    chk("lu_bubble_valid", q_valid, 0);
    chk("lu_bubble_rd", q_rd, 31);
    chk("lu_bubble_ctrl", q_ctrl, 0);
    chk("lu_count", stall_count, 1);
    clr_producers();
    mem_regwrite = 1; mem_rd = 9; mem_result = 64'h55;
    #1 chk("lu_release", id_stall, 0);
    cyc();
    chk("lu_valid", q_valid, 1);
    chk("lu_op_b", q_op_b, 64'h55);

    // Unused source never stalls
    clr_producers();
    decode(3, 9, 12, 1, 0);
    load_in_ex(9);
    #1 chk("unused_no_stall", id_stall, 0);
    cyc();
    chk("unused_valid", q_valid, 1);
    chk("unused_count", stall_count, 1);

    // Empty decode slot never stalls
    id_valid = 0; id_use_rm = 1;
    #1 chk("bubble_no_stall", id_stall, 0);
    cyc();
    chk("bubble_valid", q_valid, 0);

    // Flush during hazard
    decode(3, 9, 13, 1, 1);
    flush = 1;
    #1 chk("flush_no_stall", id_stall, 0);
    cyc();
    chk("flush_valid", q_valid, 0);
    chk("flush_count", stall_count, 1);
    flush = 0;
    cyc();
    chk("stall2_count", stall_count, 2);

    // Async reset mid-stall, checked well before the next edge
    #2;
    reset = 1; id_valid = 0;
    #1;
    chk("mid_rst_valid", q_valid, 0);
    chk("mid_rst_rd", q_rd, 31);
    chk("mid_rst_op_b", q_op_b, 0);
    chk("mid_rst_imm", q_imm, 0);
    chk("mid_rst_count", stall_count, 0);
    chk("mid_rst_stall", id_stall, 0);
    @(negedge clk); #1 reset = 0;
    clr_producers();
    decode(4, 3, 14, 1, 1);
    cyc();
    chk("post_rst_op_a", q_op_a, 64'h22);
    chk("post_rst_op_b", q_op_b, 64'h11);
    cyc();
    @(negedge clk); #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
